// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller: sequencer states,
// forwarding-source codes and control-word geometry.
package pipeline_pkg;

   // Sequencer states; the spare 2'b11 encoding is recovered to ST_RUN.
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   // Operand source select codes for the ALU input muxes.
   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   // ID/EX control word width and the position of the 'ta' flag inside it.
   localparam int CTRL_W = 22;
   localparam int TA_BIT = 7;

endpackage

// File: rtl/fwd_select_unit.sv
// Purely combinational register-specifier comparator: picks the forwarding
// source for each ID operand and flags a load-use hazard against EX.
module fwd_select_unit
   import pipeline_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] mem_rd,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             ex_rf_le,
   input  logic             mem_rf_le,
   input  logic             wb_rf_le,
   input  logic             ex_load,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             load_use
);

   // Nearest producing stage wins; register 0 is hard-wired and never forwarded.
   function automatic logic [1:0] pick_src(
      input logic             use_rs,
      input logic [REG_W-1:0] rs,
      input logic [REG_W-1:0] rd_ex,
      input logic             le_ex,
      input logic [REG_W-1:0] rd_mem,
      input logic             le_mem,
      input logic [REG_W-1:0] rd_wb,
      input logic             le_wb
   );
      logic [1:0] src;
      src = FWD_RF;
      if (use_rs && (rs != '0)) begin
         if (le_ex && (rd_ex == rs))        src = FWD_EX;
         else if (le_mem && (rd_mem == rs)) src = FWD_MEM;
         else if (le_wb && (rd_wb == rs))   src = FWD_WB;
      end
      return src;
   endfunction

   // Forwarding selects and the load-use hazard are evaluated every cycle.
   always_comb begin
      fwd_a = pick_src(id_use_rs1, id_rs1, ex_rd, ex_rf_le, mem_rd, mem_rf_le,
                       wb_rd, wb_rf_le);
      fwd_b = pick_src(id_use_rs2, id_rs2, ex_rd, ex_rf_le, mem_rd, mem_rf_le,
                       wb_rd, wb_rf_le);
      load_use = ex_load && ex_rf_le && (ex_rd != '0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer beside the ID stage: stalls one cycle on load-use,
// drains the pipe after a 'ta' and then redirects the PC to the trap vector,
// while counting stall cycles in a saturating counter.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int REG_W        = 5,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_ta_instr,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] mem_rd,
   input  logic [REG_W-1:0] wb_rd,
   input  logic             ex_rf_le,
   input  logic             mem_rf_le,
   input  logic             wb_rf_le,
   input  logic             ex_load,
   output logic             pc_le,
   output logic             npc_le,
   output logic             ifid_le,
   output logic             ifid_flush,
   output logic             nop_sel,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             trap_redirect,
   output logic [CNT_W-1:0] stall_cnt
);

   // Drain counter only needs to hold DRAIN_CYCLES-1.
   localparam int DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);

   state_t          state, state_next;
   logic [DC_W-1:0] drain_cnt, drain_cnt_next;
   logic [1:0]      fwd_a_raw, fwd_b_raw;
   logic            load_use;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
   endfunction

   fwd_select_unit #(.REG_W(REG_W)) u_fwd (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .ex_rd      (ex_rd),
      .mem_rd     (mem_rd),
      .wb_rd      (wb_rd),
      .ex_rf_le   (ex_rf_le),
      .mem_rf_le  (mem_rf_le),
      .wb_rf_le   (wb_rf_le),
      .ex_load    (ex_load),
      .fwd_a      (fwd_a_raw),
      .fwd_b      (fwd_b_raw),
      .load_use   (load_use)
   );

   // Forwarding is suppressed while the pipe is held in reset.
   assign fwd_a = reset ? FWD_RF : fwd_a_raw;
   assign fwd_b = reset ? FWD_RF : fwd_b_raw;

   // State and drain counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
      end else begin
         state     <= state_next;
         drain_cnt <= drain_cnt_next;
      end
   end

   // Next-state and Mealy outputs; load-use takes precedence over a trap in ID.
   always_comb begin
      state_next     = state;
      drain_cnt_next = drain_cnt;
      pc_le          = 1'b1;
      npc_le         = 1'b1;
      ifid_le        = 1'b1;
      ifid_flush     = 1'b0;
      nop_sel        = 1'b0;
      trap_redirect  = 1'b0;
      case (state)
         ST_RUN: begin
            if (load_use) begin
               pc_le   = 1'b0;
               npc_le  = 1'b0;
               ifid_le = 1'b0;
               nop_sel = 1'b1;
            end else if (id_ta_instr) begin
               pc_le          = 1'b0;
               npc_le         = 1'b0;
               ifid_le        = 1'b0;
               state_next     = ST_DRAIN;
               drain_cnt_next = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            pc_le   = 1'b0;
            npc_le  = 1'b0;
            ifid_le = 1'b0;
            nop_sel = 1'b1;
            if (drain_cnt == '0) state_next = ST_REDIRECT;
            else                 drain_cnt_next = drain_cnt - DC_W'(1);
         end
         ST_REDIRECT: begin
            trap_redirect = 1'b1;
            ifid_flush    = 1'b1;
            ifid_le       = 1'b0;
            nop_sel       = 1'b1;
            state_next    = ST_RUN;
         end
         default: begin
            pc_le          = 1'b0;
            npc_le         = 1'b0;
            ifid_le        = 1'b0;
            nop_sel        = 1'b1;
            state_next     = ST_RUN;
            drain_cnt_next = '0;
         end
      endcase
      if (reset) begin
         pc_le         = 1'b0;
         npc_le        = 1'b0;
         ifid_le       = 1'b0;
         ifid_flush    = 1'b0;
         nop_sel       = 1'b1;
         trap_redirect = 1'b0;
      end
   end

   // Saturating count of cycles in which the PC was held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       stall_cnt <= '0;
      else if (!pc_le) stall_cnt <= sat_inc(stall_cnt);
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (REG_W=5, DRAIN_CYCLES=3, CNT_W=4).
module tb_pipeline_hazard_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
   logic       id_use_rs1, id_use_rs2, id_ta_instr;
   logic       ex_rf_le, mem_rf_le, wb_rf_le, ex_load;
   logic       pc_le, npc_le, ifid_le, ifid_flush, nop_sel, trap_redirect;
   logic [1:0] fwd_a, fwd_b;
   logic [3:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   pipeline_hazard_ctrl #(.REG_W(5), .DRAIN_CYCLES(3), .CNT_W(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_use_rs1    (id_use_rs1),
      .id_use_rs2    (id_use_rs2),
      .id_ta_instr   (id_ta_instr),
      .ex_rd         (ex_rd),
      .mem_rd        (mem_rd),
      .wb_rd         (wb_rd),
      .ex_rf_le      (ex_rf_le),
      .mem_rf_le     (mem_rf_le),
      .wb_rf_le      (wb_rf_le),
      .ex_load       (ex_load),
      .pc_le         (pc_le),
      .npc_le        (npc_le),
      .ifid_le       (ifid_le),
      .ifid_flush    (ifid_flush),
      .nop_sel       (nop_sel),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b),
      .trap_redirect (trap_redirect),
      .stall_cnt     (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr_inputs();
      id_rs1 = 0; id_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; id_ta_instr = 0;
      ex_rf_le = 0; mem_rf_le = 0; wb_rf_le = 0; ex_load = 0;
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load_use();
      ex_load = 1; ex_rf_le = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
   endtask

   initial begin
      clr_inputs();
      reset = 1'b1;
      // A plain EX match while in reset must not forward
      ex_rd = 1; ex_rf_le = 1; id_rs1 = 1; id_use_rs1 = 1;
      #3;
      chk("rst_pc_le",   pc_le, 0);
      chk("rst_npc_le",  npc_le, 0);
      chk("rst_ifid_le", ifid_le, 0);
      chk("rst_nop_sel", nop_sel, 1);
      chk("rst_flush",   ifid_flush, 0);
      chk("rst_trap",    trap_redirect, 0);
      chk("rst_fwd_a",   fwd_a, 0);
      chk("rst_stall",   stall_cnt, 0);
      #9 reset = 1'b0;                 // released at t=12, between edges
      clr_inputs();
      #1;
      chk("run_pc_le",   pc_le, 1);
      chk("run_nop_sel", nop_sel, 0);

      // Test 1: load-use gives exactly one bubble, then MEM forwarding
      step();
      set_load_use();
      #1;
      chk("lu_pc_le",    pc_le, 0);
      chk("lu_npc_le",   npc_le, 0);
      chk("lu_ifid_le",  ifid_le, 0);
      chk("lu_nop_sel",  nop_sel, 1);
      chk("lu_fwd_a_ex", fwd_a, 1);
      step();
      clr_inputs();
      mem_rd = 5; mem_rf_le = 1; id_rs1 = 5; id_use_rs1 = 1;
      #1;
      chk("lu_after_pc_le",  pc_le, 1);
      chk("lu_after_nop",    nop_sel, 0);
      chk("lu_after_fwd_a",  fwd_a, 2);
      chk("lu_after_stall",  stall_cnt, 1);

      // Test 2: forwarding priority on operand b
      step();
      clr_inputs();
      id_rs2 = 3; id_use_rs2 = 1;
      ex_rd = 3; mem_rd = 3; wb_rd = 3;
      ex_rf_le = 1; mem_rf_le = 1; wb_rf_le = 1;
      #1 chk("fwd_b_ex", fwd_b, 1);
      chk("fwd_b_nostall", pc_le, 1);
      chk("fwd_a_none", fwd_a, 0);
      ex_rf_le = 0;
      #1 chk("fwd_b_mem", fwd_b, 2);
      mem_rf_le = 0;
      #1 chk("fwd_b_wb", fwd_b, 3);
      id_use_rs2 = 0;
      #1 chk("fwd_b_nouse", fwd_b, 0);
      id_use_rs2 = 1; id_rs2 = 0; wb_rd = 0;
      #1 chk("fwd_b_r0", fwd_b, 0);

      // Test 3: ta drain and redirect, DRAIN_CYCLES=3
      step();
      clr_inputs();
      id_ta_instr = 1;
      #1;
      chk("ta_T_nop",   nop_sel, 0);
      chk("ta_T_pc_le", pc_le, 0);
      chk("ta_T_trap",  trap_redirect, 0);
      for (int i = 1; i <= 3; i++) begin
         step();
         id_ta_instr = 0;
         #1;
         chk($sformatf("ta_drain%0d_nop", i),   nop_sel, 1);
         chk($sformatf("ta_drain%0d_pc_le", i), pc_le, 0);
         chk($sformatf("ta_drain%0d_trap", i),  trap_redirect, 0);
      end
      step();
      chk("ta_redir_trap",  trap_redirect, 1);
      chk("ta_redir_flush", ifid_flush, 1);
      chk("ta_redir_pc_le", pc_le, 1);
      chk("ta_redir_npc",   npc_le, 1);
      chk("ta_redir_nop",   nop_sel, 1);
      chk("ta_redir_stall", stall_cnt, 5);
      step();
      chk("ta_post_trap",  trap_redirect, 0);
      chk("ta_post_flush", ifid_flush, 0);
      chk("ta_post_pc_le", pc_le, 1);
      chk("ta_post_nop",   nop_sel, 0);

      // Test 4: load-use and ta together; bubble first, redirect at T+5
      clr_inputs();
      set_load_use();
      id_ta_instr = 1;
      #1;
      chk("both_T_nop",   nop_sel, 1);
      chk("both_T_pc_le", pc_le, 0);
      step();
      clr_inputs();
      id_ta_instr = 1;
      #1;
      chk("both_T1_nop",   nop_sel, 0);
      chk("both_T1_pc_le", pc_le, 0);
      for (int i = 2; i <= 4; i++) begin
         step();
         id_ta_instr = 0;
         #1;
         chk($sformatf("both_T%0d_nop", i),  nop_sel, 1);
         chk($sformatf("both_T%0d_trap", i), trap_redirect, 0);
      end
      step();
      chk("both_T5_trap",  trap_redirect, 1);
      chk("both_T5_stall", stall_cnt, 10);
      step();
      chk("both_T6_trap", trap_redirect, 0);

      // Test 5: async reset pulse in the middle of DRAIN
      clr_inputs();
      id_ta_instr = 1;
      step();
      id_ta_instr = 0;
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_pc_le", pc_le, 0);
      chk("mid_rst_nop",   nop_sel, 1);
      chk("mid_rst_stall", stall_cnt, 0);
      #2 reset = 1'b0;
      #1;
      chk("mid_rel_pc_le", pc_le, 1);
      chk("mid_rel_nop",   nop_sel, 0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("mid_no_trap%0d", i), trap_redirect, 0);
      end
      chk("mid_stall", stall_cnt, 0);

      // Test 6: held load-use saturates the 4-bit counter at 15
      set_load_use();
      for (int i = 1; i <= 20; i++) begin
         step();
         chk($sformatf("sat_cyc%0d", i), stall_cnt, (i > 15) ? 15 : i);
      end
      chk("sat_pc_le", pc_le, 0);
      clr_inputs();
      step();
      chk("sat_hold", stall_cnt, 15);
      chk("sat_run_pc_le", pc_le, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
